// File: rtl/matmul_nxn_seq.sv
// matmul_nxn_seq
//   N x N integer matrix multiplier: C = A*B, or C = C + A*B in accumulate
//   mode. Every element of C has its own multiplier and accumulator. Each
//   compute cycle adds one k-term A(i,k)*B(k,j) into every accumulator, so
//   one product takes N compute cycles after the start edge.
//
// Parameters
//   N       matrix dimension (N >= 2)
//   DW      operand element width
//   SIGNED  1 = two's complement operands/results, 0 = unsigned
//   OW      result element width, 2*DW + $clog2(N) (derived)
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   start   request a product; taken only while busy = 0 and abort = 0
//   abort   cancels a running product; C is not written
//   accum   sampled with start: 1 = C + A*B, 0 = A*B
//   a_flat  A, row-major, DW bits per element
//   b_flat  B, same packing as A
//   c_flat  C, row-major, OW bits per element; only written on completion
//   busy    high while a product is in progress
//   done    one-cycle pulse after c_flat has been updated
module matmul_nxn_seq #(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    localparam int OW    = 2 * DW + $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  accum,
    input  logic [N*N*DW-1:0]     a_flat,
    input  logic [N*N*DW-1:0]     b_flat,
    output logic [N*N*OW-1:0]     c_flat,
    output logic                  busy,
    output logic                  done
);

    localparam int KW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [KW-1:0]     k_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [N*N*DW-1:0] a_reg;
    logic [N*N*DW-1:0] b_reg;

    logic load;
    logic step;
    logic last_step;

    // abort has priority over start in IDLE and over the final write in RUN.
    assign load      = (state_reg == IDLE) && start && !abort;
    assign step      = (state_reg == RUN) && !abort;
    assign last_step = (k_reg == KW'(N - 1));

    // Control FSM. Operands are captured on the accepting edge so that the
    // caller may change a_flat/b_flat freely while the product runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        a_reg     <= a_flat;
                        b_reg     <= b_flat;
                        k_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        k_reg     <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (last_step) begin
                        k_reg     <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

    // One multiply-accumulate lane per C(i,j).
    generate
        for (genvar gi = 0; gi < N * N; gi++) begin : g_elem
            localparam int RI = gi / N;
            localparam int CJ = gi % N;

            logic [DW-1:0]        a_sel;
            logic [DW-1:0]        b_sel;
            logic signed [DW:0]   a_ext;
            logic signed [DW:0]   b_ext;
            logic signed [OW-1:0] prod;
            logic [OW-1:0]        acc_reg;
            logic [OW-1:0]        acc_next;
            logic [OW-1:0]        c_reg;

            // Pick A(i,k) and B(k,j) for the current k.
            always_comb begin
                a_sel = '0;
                b_sel = '0;
                for (int k = 0; k < N; k++) begin
                    if (k_reg == KW'(k)) begin
                        a_sel = a_reg[(RI * N + k) * DW +: DW];
                        b_sel = b_reg[(k * N + CJ) * DW +: DW];
                    end
                end
            end

            // One extra bit makes both modes a signed multiply: the top bit
            // is a copy of the sign in signed mode and zero otherwise. OW is
            // at least 2*DW+1, so the low OW bits of the widened product are
            // exact, and the accumulator simply wraps modulo 2^OW.
            assign a_ext    = $signed({(SIGNED != 0) ? a_sel[DW-1] : 1'b0, a_sel});
            assign b_ext    = $signed({(SIGNED != 0) ? b_sel[DW-1] : 1'b0, b_sel});
            assign prod     = OW'(a_ext) * OW'(b_ext);
            assign acc_next = acc_reg + prod;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_reg <= '0;
                    c_reg   <= '0;
                end else if (load) begin
                    acc_reg <= accum ? c_reg : '0;
                end else if (step) begin
                    acc_reg <= acc_next;
                    if (last_step) begin
                        c_reg <= acc_next;
                    end
                end
            end

            assign c_flat[gi*OW +: OW] = c_reg;
        end
    endgenerate

endmodule

// File: tb/tb_matmul_nxn_seq.sv
// tb_matmul_nxn_seq
//   Three instances: u0 (N=3, DW=8, unsigned), u1 (N=3, DW=8, signed) and
//   u2 (N=4, DW=4, unsigned). A behavioural model computes each whole
//   product with plain integer arithmetic when a start is accepted and
//   releases it N edges later; a compare process checks C, busy and done
//   of all three instances on every falling edge. Directed sequences add
//   hand-computed literal expectations.
module tb_matmul_nxn_seq;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, one row per instance. Element values are plain integers.
    int   in_a [3][16];
    int   in_b [3][16];
    logic in_start [3];
    logic in_abort [3];
    logic in_accum [3];

    logic [71:0]  a0, b0, a1, b1;
    logic [63:0]  a2, b2;
    logic [161:0] c0, c1;
    logic [159:0] c2;
    logic         busy0, busy1, busy2;
    logic         done0, done1, done2;

    always_comb begin
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        for (int e = 0; e < 9; e++) begin
            a0[e*8 +: 8] = in_a[0][e][7:0];
            b0[e*8 +: 8] = in_b[0][e][7:0];
            a1[e*8 +: 8] = in_a[1][e][7:0];
            b1[e*8 +: 8] = in_b[1][e][7:0];
        end
        for (int e = 0; e < 16; e++) begin
            a2[e*4 +: 4] = in_a[2][e][3:0];
            b2[e*4 +: 4] = in_b[2][e][3:0];
        end
    end

    matmul_nxn_seq #(.N(3), .DW(8), .SIGNED(0)) u0 (
        .clk(clk), .reset(reset), .start(in_start[0]), .abort(in_abort[0]),
        .accum(in_accum[0]), .a_flat(a0), .b_flat(b0), .c_flat(c0),
        .busy(busy0), .done(done0));

    matmul_nxn_seq #(.N(3), .DW(8), .SIGNED(1)) u1 (
        .clk(clk), .reset(reset), .start(in_start[1]), .abort(in_abort[1]),
        .accum(in_accum[1]), .a_flat(a1), .b_flat(b1), .c_flat(c1),
        .busy(busy1), .done(done1));

    matmul_nxn_seq #(.N(4), .DW(4), .SIGNED(0)) u2 (
        .clk(clk), .reset(reset), .start(in_start[2]), .abort(in_abort[2]),
        .accum(in_accum[2]), .a_flat(a2), .b_flat(b2), .c_flat(c2),
        .busy(busy2), .done(done2));

    function automatic int nd(int d);
        return (d == 2) ? 4 : 3;
    endfunction

    function automatic int ow(int d);
        return (d == 2) ? 10 : 18;
    endfunction

    function automatic longint msk(int d);
        return (longint'(1) << ow(d)) - 1;
    endfunction

    function automatic longint get_c(int d, int e);
        case (d)
            0:       return longint'(c0[e*18 +: 18]);
            1:       return longint'(c1[e*18 +: 18]);
            default: return longint'(c2[e*10 +: 10]);
        endcase
    endfunction

    function automatic logic get_busy(int d);
        case (d)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(int d);
        case (d)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    longint exp_c [3][16];
    longint pend  [3][16];
    bit     exp_busy [3];
    bit     exp_done [3];
    int     cnt [3];

    always @(posedge clk or negedge reset) begin
        longint s;
        int     n;
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                exp_busy[d] = 1'b0;
                exp_done[d] = 1'b0;
                cnt[d]      = 0;
                for (int e = 0; e < 16; e++) exp_c[d][e] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                n = nd(d);
                exp_done[d] = 1'b0;
                if (!exp_busy[d]) begin
                    if (in_start[d] && !in_abort[d]) begin
                        for (int i = 0; i < n; i++) begin
                            for (int j = 0; j < n; j++) begin
                                s = in_accum[d] ? exp_c[d][i*n+j] : 0;
                                for (int k = 0; k < n; k++)
                                    s += longint'(in_a[d][i*n+k]) * longint'(in_b[d][k*n+j]);
                                pend[d][i*n+j] = s & msk(d);
                            end
                        end
                        exp_busy[d] = 1'b1;
                        cnt[d]      = n;
                    end
                end else if (in_abort[d]) begin
                    exp_busy[d] = 1'b0;
                end else begin
                    cnt[d] = cnt[d] - 1;
                    if (cnt[d] == 0) begin
                        for (int e = 0; e < 16; e++) exp_c[d][e] = pend[d][e];
                        exp_busy[d] = 1'b0;
                        exp_done[d] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int d, input longint got, input longint want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s u%0d: got %0d, expected %0d (t=%0t)", name, d, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                check("model_busy", d, longint'(get_busy(d)), longint'(exp_busy[d]));
                check("model_done", d, longint'(get_done(d)), longint'(exp_done[d]));
                for (int e = 0; e < nd(d) * nd(d); e++)
                    check($sformatf("model_c[%0d]", e), d, get_c(d, e), exp_c[d][e]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_all(input int d, input int av, input int bv);
        for (int e = 0; e < 16; e++) begin
            in_a[d][e] = av;
            in_b[d][e] = bv;
        end
    endtask

    // A = identity, B = 1..N*N
    task automatic set_ident_seq(input int d);
        for (int e = 0; e < 16; e++) begin
            in_a[d][e] = (e < nd(d) * nd(d) && e / nd(d) == e % nd(d)) ? 1 : 0;
            in_b[d][e] = e + 1;
        end
    endtask

    // Starts a product (called at a falling edge) and returns at the falling
    // edge where done is seen, checking the latency from the accepting edge.
    task automatic run(input int d, input bit acc);
        int lat;
        in_start[d] = 1'b1;
        in_accum[d] = acc;
        @(negedge clk);
        in_start[d] = 1'b0;
        lat = 0;
        while (!get_done(d) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", d, longint'(lat), longint'(nd(d)));
    endtask

    task automatic wait_done(input int d, input string name);
        int lat;
        lat = 0;
        while (!get_done(d) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(name, d, longint'(get_done(d)), 1);
    endtask

    task automatic chk_all(input string name, input int d, input longint want);
        for (int e = 0; e < nd(d) * nd(d); e++)
            check($sformatf("%s[%0d]", name, e), d, get_c(d, e), want);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_start[d] = 1'b0;
            in_abort[d] = 1'b0;
            in_accum[d] = 1'b0;
            set_all(d, 0, 0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        check("reset_busy", 0, longint'(busy0), 0);
        check("reset_done", 0, longint'(done0), 0);
        chk_all("reset_c", 0, 0);

        // 1: identity x 1..9
        set_ident_seq(0);
        run(0, 1'b0);
        for (int e = 0; e < 9; e++) check($sformatf("ident_c[%0d]", e), 0, get_c(0, e), e + 1);
        @(negedge clk);
        check("done_width", 0, longint'(done0), 0);

        // 2: unsigned maximum
        set_all(0, 255, 255);
        run(0, 1'b0);
        chk_all("umax_c", 0, 195075);

        // 3: signed mode
        set_all(1, -128, -128);
        run(1, 1'b0);
        chk_all("smin_c", 1, 49152);
        set_all(1, -1, 2);
        run(1, 1'b0);
        chk_all("sneg_c", 1, 262138);        // -6 in 18 bits

        // 4: accumulate
        for (int e = 0; e < 16; e++) begin
            in_a[0][e] = (e < 9 && e / 3 == e % 3) ? 1 : 0;
            in_b[0][e] = in_a[0][e];
        end
        run(0, 1'b0);
        check("acc0_diag", 0, get_c(0, 4), 1);
        run(0, 1'b1);
        for (int e = 0; e < 9; e++)
            check($sformatf("acc1_c[%0d]", e), 0, get_c(0, e), (e / 3 == e % 3) ? 2 : 0);

        // 6: N=4, DW=4
        set_all(2, 15, 15);
        run(2, 1'b0);
        chk_all("n4_c", 2, 900);

        // 5a: start held while busy, operands changed mid-run
        set_ident_seq(0);
        in_start[0] = 1'b1;
        in_accum[0] = 1'b0;
        @(negedge clk);
        set_all(0, 7, 7);
        @(negedge clk);
        @(negedge clk);
        in_start[0] = 1'b0;
        wait_done(0, "busy_start_done");
        for (int e = 0; e < 9; e++) check($sformatf("busy_start_c[%0d]", e), 0, get_c(0, e), e + 1);
        @(negedge clk);
        check("no_queue_busy", 0, longint'(busy0), 0);

        // 5b: abort while k=1
        set_all(0, 255, 255);
        in_start[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        @(negedge clk);
        in_abort[0] = 1'b1;
        @(negedge clk);
        in_abort[0] = 1'b0;
        check("abort_busy", 0, longint'(busy0), 0);
        repeat (4) @(negedge clk);
        check("abort_c4", 0, get_c(0, 4), 5);

        // abort beats start in IDLE
        in_start[0] = 1'b1;
        in_abort[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        in_abort[0] = 1'b0;
        check("idle_abort_busy", 0, longint'(busy0), 0);

        // 5c: abort on the completing edge
        in_start[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in_abort[0] = 1'b1;
        @(negedge clk);
        in_abort[0] = 1'b0;
        check("abort_en_done", 0, longint'(done0), 0);
        check("abort_en_c8", 0, get_c(0, 8), 9);

        // 5d: back-to-back start on the done cycle
        set_ident_seq(0);
        in_b[0][0] = 4;
        run(0, 1'b0);
        check("b2b_first_c0", 0, get_c(0, 0), 4);
        set_all(0, 1, 1);
        in_start[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        check("b2b_busy", 0, longint'(busy0), 1);
        wait_done(0, "b2b_done");
        chk_all("b2b_c", 0, 3);

        // 5e: reset during RUN
        set_all(0, 5, 5);
        in_start[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_run_busy", 0, longint'(busy0), 0);
        check("rst_run_done", 0, longint'(done0), 0);
        chk_all("rst_run_c", 0, 0);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_after_busy", 0, longint'(busy0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
